// File: rtl/burst_mem_arbiter.sv
// Round-robin arbiter between I-side and D-side line clients onto a single
// beat-serial burst memory port; reassembles read beats into full lines.
module burst_mem_arbiter #(
   parameter int BEATS  = 4,
   parameter int BEAT_W = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_read,
   input  logic                      i_write,
   input  logic [31:0]               i_address,
   input  logic [BEATS*BEAT_W-1:0]   i_wdata,
   output logic [BEATS*BEAT_W-1:0]   i_rdata,
   output logic                      i_resp,
   input  logic                      d_read,
   input  logic                      d_write,
   input  logic [31:0]               d_address,
   input  logic [BEATS*BEAT_W-1:0]   d_wdata,
   output logic [BEATS*BEAT_W-1:0]   d_rdata,
   output logic                      d_resp,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [31:0]               mem_address,
   output logic [BEAT_W-1:0]         mem_wdata,
   input  logic [BEAT_W-1:0]         mem_rdata,
   input  logic                      mem_resp
);
   localparam int LINE_W = BEATS * BEAT_W;
   localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state_reg;
   logic [KW-1:0]     k_reg;
   logic [31:0]       addr_reg;
   logic [LINE_W-1:0] wline_reg;
   logic [LINE_W-1:0] rline_reg;
   logic [LINE_W-1:0] rline_next;
   logic              client_reg;   // 1 = D-side, 0 = I-side
   logic              last_d_reg;   // 1 when D was served most recently
   logic [BEAT_W-1:0] wbeat [BEATS];
   logic              i_req;
   logic              d_req;
   logic              grant_d;
   logic              last_beat;

   // Beat view of the latched write line and the read line with beat k merged in.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign wbeat[gi] = wline_reg[gi*BEAT_W +: BEAT_W];
         assign rline_next[gi*BEAT_W +: BEAT_W] =
            (k_reg == KW'(gi)) ? mem_rdata : rline_reg[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   always_comb begin
      i_req     = i_read | i_write;
      d_req     = d_read | d_write;
      // On a tie the client not served last wins; reset leaves D favoured.
      grant_d   = d_req & (~i_req | ~last_d_reg);
      last_beat = mem_resp && (k_reg == KW'(BEATS - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         k_reg      <= '0;
         addr_reg   <= '0;
         wline_reg  <= '0;
         rline_reg  <= '0;
         client_reg <= 1'b0;
         last_d_reg <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_req || d_req) begin
                  client_reg <= grant_d;
                  addr_reg   <= grant_d ? d_address : i_address;
                  wline_reg  <= grant_d ? d_wdata : i_wdata;
                  k_reg      <= '0;
                  state_reg  <= (grant_d ? d_write : i_write) ? WR : RD;
               end
            end
            RD: begin
               if (mem_resp) begin
                  rline_reg <= rline_next;
                  k_reg     <= k_reg + KW'(1);
                  if (last_beat) begin
                     k_reg     <= '0;
                     state_reg <= DONE;
                     if (client_reg) d_rdata <= rline_next;
                     else            i_rdata <= rline_next;
                  end
               end
            end
            WR: begin
               if (mem_resp) begin
                  k_reg <= k_reg + KW'(1);
                  if (last_beat) begin
                     k_reg     <= '0;
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               last_d_reg <= client_reg;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign mem_read    = (state_reg == RD);
   assign mem_write   = (state_reg == WR);
   assign mem_address = addr_reg;
   assign mem_wdata   = wbeat[k_reg];
   assign i_resp      = (state_reg == DONE) && !client_reg;
   assign d_resp      = (state_reg == DONE) && client_reg;

endmodule
